// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with optional 2-entry skid buffer
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int SKID   = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [DATA_W-1:0] In_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [DATA_W-1:0] Out_Data,
    output logic [1:0]        Occupancy
);
    // The state encoding doubles as the entry count, so Occupancy is the state itself.
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_main;
    logic              w_accept;
    logic              w_consume;

    assign Out_Valid = (r_state != EMPTY);
    assign Out_Data  = r_main;
    assign Occupancy = r_state;
    assign w_consume = Out_Valid & Out_Ready;
    assign w_accept  = In_Valid & In_Ready & ~Flush;

    if (SKID != 0) begin : g_skid
        logic [DATA_W-1:0] r_skid;
        logic              r_in_ready;
        logic              w_load_main;
        logic              w_load_skid;
        logic              w_skid_to_main;

        // Ready comes straight from a flop so upstream never sees Out_Ready combinationally.
        assign In_Ready = r_in_ready;

        // Next-state and data steering; Flush empties the stage regardless of handshakes.
        always_comb begin
            w_next         = r_state;
            w_load_main    = 1'b0;
            w_load_skid    = 1'b0;
            w_skid_to_main = 1'b0;
            if (Flush) begin
                w_next = EMPTY;
            end else begin
                case (r_state)
                    EMPTY: begin
                        w_next      = w_accept ? ONE : EMPTY;
                        w_load_main = w_accept;
                    end
                    ONE: begin
                        w_next      = (w_accept & ~w_consume) ? FULL :
                                      (~w_accept & w_consume) ? EMPTY : ONE;
                        w_load_main = w_accept & w_consume;
                        w_load_skid = w_accept & ~w_consume;
                    end
                    FULL: begin
                        w_next         = w_consume ? ONE : FULL;
                        w_skid_to_main = w_consume;
                    end
                    default: w_next = EMPTY;
                endcase
            end
        end

        // State and registered ready; ready drops during reset and whenever the next state is FULL.
        always_ff @(posedge Clk) begin
            if (Reset) begin
                r_state    <= EMPTY;
                r_in_ready <= 1'b0;
            end else begin
                r_state    <= w_next;
                r_in_ready <= (w_next != FULL);
            end
        end

        // Payload registers only move on accept or skid promotion; consume and Flush leave them alone.
        always_ff @(posedge Clk) begin
            if (Reset) begin
                r_main <= '0;
                r_skid <= '0;
            end else begin
                if (w_load_main)
                    r_main <= In_Data;
                else if (w_skid_to_main)
                    r_main <= r_skid;
                if (w_load_skid)
                    r_skid <= In_Data;
            end
        end
    end else begin : g_single
        // A single entry can take a new payload whenever it is empty or being drained.
        assign In_Ready = ~Out_Valid | Out_Ready;

        // Next-state: accept wins over consume since it refills the entry being drained.
        always_comb begin
            w_next = r_state;
            if (Flush)
                w_next = EMPTY;
            else if (w_accept)
                w_next = ONE;
            else if (w_consume)
                w_next = EMPTY;
        end

        // State register.
        always_ff @(posedge Clk) begin
            if (Reset)
                r_state <= EMPTY;
            else
                r_state <= w_next;
        end

        // Payload register loads only on accept.
        always_ff @(posedge Clk) begin
            if (Reset)
                r_main <= '0;
            else if (w_accept)
                r_main <= In_Data;
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: vector table, streaming scoreboard and directed corners for both stage variants
module tb_pipe_stage_reg;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        rst1, fl1, iv1, ir1, ov1, or1;
    logic [31:0] id1, od1;
    logic [1:0]  oc1;
    logic        rst0, fl0, iv0, ir0, ov0, or0;
    logic [7:0]  id0, od0;
    logic [1:0]  oc0;

    pipe_stage_reg #(.DATA_W(32), .SKID(1)) u_skid (
        .Clk(clk), .Reset(rst1), .Flush(fl1), .In_Valid(iv1), .In_Ready(ir1), .In_Data(id1),
        .Out_Valid(ov1), .Out_Ready(or1), .Out_Data(od1), .Occupancy(oc1)
    );

    pipe_stage_reg #(.DATA_W(8), .SKID(0)) u_single (
        .Clk(clk), .Reset(rst0), .Flush(fl0), .In_Valid(iv0), .In_Ready(ir0), .In_Data(id0),
        .Out_Valid(ov0), .Out_Ready(or0), .Out_Data(od0), .Occupancy(oc0)
    );

    typedef struct {
        logic        rst, fl, iv;
        logic [31:0] d;
        logic        ordy;
        logic        ov;
        logic [31:0] od;
        logic        cd;
        logic [1:0]  oc;
        logic        ir;
    } vec_t;

    vec_t        tv[$];
    logic [31:0] sb[$];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic rst, logic fl, logic iv, logic [31:0] d, logic ordy,
                                logic ov, logic [31:0] od, logic cd, logic [1:0] oc, logic ir);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
        v.ov = ov; v.od = od; v.cd = cd; v.oc = oc; v.ir = ir;
        return v;
    endfunction

    initial begin
        int sent, got, cyc;
        logic [31:0] exp_v, prev_d;
        logic prev_hold;

        rst1 = 1'b1; fl1 = 1'b0; iv1 = 1'b0; id1 = '0; or1 = 1'b0;
        rst0 = 1'b1; fl0 = 1'b0; iv0 = 1'b0; id0 = '0; or0 = 1'b0;

        //            rst fl iv data          ordy  ov od            cd oc ir
        tv.push_back(mk(1, 0, 1, 32'hDEADBEEF, 0,   0, 32'h0,        1, 0, 0));
        tv.push_back(mk(0, 0, 0, 32'h0,        0,   0, 32'h0,        1, 0, 1));
        tv.push_back(mk(0, 0, 1, 32'hA5A5A5A5, 1,   1, 32'hA5A5A5A5, 1, 1, 1));
        tv.push_back(mk(0, 0, 0, 32'h0,        1,   0, 32'hA5A5A5A5, 1, 0, 1));
        tv.push_back(mk(0, 0, 1, 32'h11,       0,   1, 32'h11,       1, 1, 1));
        tv.push_back(mk(0, 0, 1, 32'h22,       0,   1, 32'h11,       1, 2, 0));
        tv.push_back(mk(0, 0, 1, 32'h33,       0,   1, 32'h11,       1, 2, 0));
        tv.push_back(mk(0, 0, 0, 32'h0,        1,   1, 32'h22,       1, 1, 1));
        tv.push_back(mk(0, 0, 1, 32'h44,       1,   1, 32'h44,       1, 1, 1));
        tv.push_back(mk(0, 0, 1, 32'h55,       0,   1, 32'h44,       1, 2, 0));
        tv.push_back(mk(0, 1, 1, 32'h99,       0,   0, 32'h44,       1, 0, 1));
        tv.push_back(mk(0, 0, 1, 32'hA1,       0,   1, 32'hA1,       1, 1, 1));
        tv.push_back(mk(0, 1, 1, 32'h99,       0,   0, 32'hA1,       1, 0, 1));
        tv.push_back(mk(0, 0, 0, 32'h0,        1,   0, 32'hA1,       1, 0, 1));
        tv.push_back(mk(0, 0, 1, 32'h66,       0,   1, 32'h66,       1, 1, 1));
        tv.push_back(mk(0, 0, 1, 32'h77,       0,   1, 32'h66,       1, 2, 0));
        tv.push_back(mk(1, 0, 1, 32'h88,       1,   0, 32'h0,        1, 0, 0));
        tv.push_back(mk(0, 0, 1, 32'hAA,       1,   0, 32'h0,        1, 0, 1));
        tv.push_back(mk(0, 0, 1, 32'hBB,       0,   1, 32'hBB,       1, 1, 1));
        tv.push_back(mk(0, 1, 0, 32'h0,        1,   0, 32'hBB,       1, 0, 1));
        tv.push_back(mk(0, 0, 1, 32'hC1,       0,   1, 32'hC1,       1, 1, 1));
        tv.push_back(mk(0, 0, 1, 32'hC2,       0,   1, 32'hC1,       1, 2, 0));
        tv.push_back(mk(0, 1, 0, 32'h0,        1,   0, 32'h0,        0, 0, 1));
        tv.push_back(mk(0, 0, 0, 32'h0,        0,   0, 32'h0,        0, 0, 1));

        tick;
        for (int i = 0; i < tv.size(); i++) begin
            rst1 = tv[i].rst; fl1 = tv[i].fl; iv1 = tv[i].iv; id1 = tv[i].d; or1 = tv[i].ordy;
            tick;
            chk($sformatf("v%0d_ov", i), {31'b0, ov1}, {31'b0, tv[i].ov});
            chk($sformatf("v%0d_occ", i), {30'b0, oc1}, {30'b0, tv[i].oc});
            chk($sformatf("v%0d_ir", i), {31'b0, ir1}, {31'b0, tv[i].ir});
            if (tv[i].cd)
                chk($sformatf("v%0d_od", i), od1, tv[i].od);
        end

        // In FULL, In_Ready must not follow Out_Ready within the cycle.
        rst1 = 1'b0; fl1 = 1'b0; or1 = 1'b0; iv1 = 1'b1; id1 = 32'h1;
        tick;
        id1 = 32'h2;
        tick;
        iv1 = 1'b0; or1 = 1'b1;
        #1;
        chk("full_ir_registered", {31'b0, ir1}, 32'd0);
        tick;
        chk("full_drain_od", od1, 32'h2);
        chk("full_drain_ir", {31'b0, ir1}, 32'd1);
        chk("full_drain_occ", {30'b0, oc1}, 32'd1);

        // Random-backpressure stream checked through the scoreboard.
        rst1 = 1'b1; iv1 = 1'b0; or1 = 1'b0;
        tick;
        rst1 = 1'b0;
        tick;
        sent = 0; got = 0; cyc = 0; prev_hold = 1'b0; prev_d = '0;
        while (got < 64 && cyc < 3000) begin
            iv1 = (sent < 64) && ($urandom_range(0, 3) != 0);
            id1 = sent + 1;
            or1 = $urandom_range(0, 1) == 1;
            #1;
            if (prev_hold) begin
                chk("stream_hold_ov", {31'b0, ov1}, 32'd1);
                chk("stream_hold_od", od1, prev_d);
            end
            if (iv1 && ir1) begin
                sb.push_back(sent + 1);
                sent++;
            end
            if (ov1 && or1) begin
                if (sb.size() == 0) begin
                    chk("stream_extra", od1, 32'hFFFFFFFF);
                end else begin
                    exp_v = sb.pop_front();
                    chk("stream_data", od1, exp_v);
                end
                got++;
            end
            prev_hold = ov1 && !or1;
            prev_d = od1;
            @(posedge clk);
            #1;
            cyc++;
        end
        iv1 = 1'b0; or1 = 1'b0;
        chk("stream_count", got, 32'd64);
        chk("stream_sb_empty", sb.size(), 32'd0);

        // Single-entry variant: combinational ready and back-to-back transfers.
        rst0 = 1'b1;
        tick;
        chk("s0_rst_ov", {31'b0, ov0}, 32'd0);
        chk("s0_rst_od", {24'b0, od0}, 32'd0);
        chk("s0_rst_occ", {30'b0, oc0}, 32'd0);
        rst0 = 1'b0; iv0 = 1'b1; id0 = 8'h5A; or0 = 1'b0;
        #1;
        chk("s0_empty_ir", {31'b0, ir0}, 32'd1);
        tick;
        chk("s0_acc_ov", {31'b0, ov0}, 32'd1);
        chk("s0_acc_od", {24'b0, od0}, 32'h5A);
        iv0 = 1'b0; or0 = 1'b0;
        #1;
        chk("s0_stall_ir", {31'b0, ir0}, 32'd0);
        or0 = 1'b1;
        #1;
        chk("s0_ready_ir", {31'b0, ir0}, 32'd1);
        iv0 = 1'b1; id0 = 8'h6B;
        tick;
        chk("s0_b2b1_od", {24'b0, od0}, 32'h6B);
        chk("s0_b2b1_occ", {30'b0, oc0}, 32'd1);
        id0 = 8'h7C;
        tick;
        chk("s0_b2b2_od", {24'b0, od0}, 32'h7C);
        chk("s0_b2b2_occ", {30'b0, oc0}, 32'd1);
        iv0 = 1'b0;
        tick;
        chk("s0_drain_ov", {31'b0, ov0}, 32'd0);
        chk("s0_drain_occ", {30'b0, oc0}, 32'd0);
        iv0 = 1'b1; id0 = 8'h11; or0 = 1'b0;
        tick;
        fl0 = 1'b1; id0 = 8'h22;
        tick;
        fl0 = 1'b0; iv0 = 1'b0;
        chk("s0_flush_ov", {31'b0, ov0}, 32'd0);
        chk("s0_flush_occ", {30'b0, oc0}, 32'd0);
        chk("s0_flush_ir", {31'b0, ir0}, 32'd1);
        chk("s0_flush_od", {24'b0, od0}, 32'h11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32: payload width in bits; legal range 1..256.
REQ-002 Parameter SKID, default 1: 1 selects a 2-entry skid-buffered stage; 0 selects a single-entry stage.
REQ-003 Clk  input  1: single clock; all state changes on its rising edge.
REQ-004 Reset  input  1: synchronous, active-high reset, sampled on the rising edge of Clk.
REQ-005 Flush  input  1: discards all held entries, for use on branch or exception.
REQ-006 In_Valid  input  1: upstream presents a valid payload.
REQ-007 In_Ready  output  1: stage accepts a payload this cycle.
REQ-008 In_Data  input  DATA_W: upstream payload.
REQ-009 Out_Valid  output  1: Out_Data holds a valid payload.
REQ-010 Out_Ready  input  1: downstream consumes the payload this cycle.
REQ-011 Out_Data  output  DATA_W: payload presented downstream.
REQ-012 Occupancy  output  2: number of held entries, 0..2 (0..1 when SKID=0).

Function
REQ-013 Accept event: In_Valid & In_Ready & ~Flush; consume event: Out_Valid & Out_Ready.
REQ-014 Latency: an accepted payload appears on Out_Data exactly 1 cycle later when the stage was empty or consumed the same cycle.
REQ-015 Ordering: payloads leave in acceptance order; none are dropped or duplicated, except by Flush or Reset.
REQ-016 While Out_Valid=1 and Out_Ready=0, Out_Data and Out_Valid hold stable.
REQ-017 SKID=1 state is the main entry (Out_*) plus a skid entry; the states are EMPTY (0), ONE (1), FULL (2).
REQ-018 SKID=1: In_Ready is a registered output, equal to 1 in EMPTY and ONE and 0 in FULL; it has no combinational path from Out_Ready.
REQ-019 SKID=1 transitions:
- EMPTY + accept -> ONE.
- ONE + accept with no consume -> FULL; the payload goes to the skid entry.
- ONE + accept + consume -> ONE; the new payload goes to main.
- ONE + consume only -> EMPTY.
- FULL + consume -> ONE; skid moves to main.
- All other combinations hold state.
REQ-020 SKID=0: In_Ready = ~Out_Valid | Out_Ready (combinational); the states are EMPTY and ONE only.
REQ-021 Flush: on the next edge Out_Valid=0, the skid entry is invalid and Occupancy=0; an In_Valid payload in the Flush cycle is discarded.
REQ-022 Flush: In_Ready=1 in the cycle after Flush.
REQ-023 Flush and consume in the same cycle: the consume completes; Flush still empties the stage.
REQ-024 Data registers load only on an accept or a skid-to-main move; they are not cleared on consume or Flush.
REQ-025 Occupancy always equals Out_Valid plus the skid-entry valid bit.
REQ-026 No X shall propagate to Out_Valid, In_Ready or Occupancy after the first reset edge.

Reset
REQ-027 While Reset=1 on an edge: Out_Valid=0, skid entry invalid, Occupancy=0 and Out_Data=0.
REQ-028 While Reset=1 on an edge: In_Ready=0 (registered, SKID=1).
REQ-029 In the first cycle after Reset deasserts: In_Ready=1.
REQ-030 Reset has priority over Flush, accept and consume; a payload presented during Reset is discarded.
REQ-031 Reset asserted mid-transfer, including in FULL, empties the stage in one edge with no partial output.

Verification
REQ-032 The bench shall cover these directed scenarios (DATA_W=32 unless noted):
- Reset, then In_Data=0xA5A5A5A5 with In_Valid=1 and Out_Ready=1 -> next cycle Out_Valid=1, Out_Data=0xA5A5A5A5, Occupancy=1.
- SKID=1: Out_Ready=0 and accept 0x11 then 0x22 -> Occupancy=2, In_Ready=0, Out_Data=0x11 held. Then Out_Ready=1 -> 0x11 leaves, next cycle Out_Data=0x22, In_Ready=1.
- Stream 0x1..0x40 with Out_Ready toggling pseudo-randomly -> the output sequence is exactly 0x1..0x40, with no gaps or repeats.
- FULL + Flush with In_Valid=1 (0x99) -> next cycle Occupancy=0 and Out_Valid=0; 0x99 never appears at the output.
- Reset asserted in FULL -> next cycle Out_Valid=0, Out_Data=0, Occupancy=0; the following cycle In_Ready=1.
- SKID=0, DATA_W=8: Out_Valid=1, Out_Ready=0 -> In_Ready=0 in the same cycle. Raise Out_Ready -> In_Ready=1 in the same cycle, and a back-to-back accept keeps Occupancy=1.
